// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one multiplier between two clients:
// captures the winner's operands, kicks the multiplier, and returns the product.
module mult_arbiter #(
    parameter int N   = 8,
    parameter int TMO = 40
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           ack0,
    output logic           ack1,
    output logic           done0,
    output logic           done1,
    output logic [2*N-1:0] p_out,
    output logic           err,
    output logic           mul_go,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    input  logic           mul_done,
    input  logic [2*N-1:0] mul_p,
    output logic           busy,
    output logic [1:0]     state
);
    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t        st_q, st_d;
    logic          gnt, last;
    logic          take, pick, timeout;
    logic [CW-1:0] cnt;

    // On a tie the client that was not served last wins.
    assign take    = req0 | req1;
    assign pick    = (req0 & req1) ? ~last : req1;
    assign timeout = (cnt == CNT_LAST);
    assign state   = st_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= IDLE;
        else     st_q <= st_d;
    end

    // Handshake outputs depend only on registered state and gnt.
    always_comb begin
        st_d   = st_q;
        ack0   = 1'b0;
        ack1   = 1'b0;
        done0  = 1'b0;
        done1  = 1'b0;
        mul_go = 1'b0;
        busy   = (st_q != IDLE);
        case (st_q)
            IDLE:  if (take) st_d = ISSUE;
            ISSUE: begin
                st_d   = WAIT;
                mul_go = 1'b1;
                ack0   = ~gnt;
                ack1   = gnt;
            end
            WAIT:  if (mul_done || timeout) st_d = RESP;
            RESP:  begin
                st_d  = IDLE;
                done0 = ~gnt;
                done1 = gnt;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt   <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
            p_out <= '0;
            err   <= 1'b0;
            mul_a <= '0;
            mul_b <= '0;
        end else begin
            case (st_q)
                IDLE: if (take) begin
                    gnt   <= pick;
                    last  <= pick;
                    cnt   <= '0;
                    mul_a <= pick ? a1 : a0;
                    mul_b <= pick ? b1 : b0;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A completion in the same cycle as the timeout still wins.
                    if (mul_done) begin
                        p_out <= mul_p;
                        err   <= 1'b0;
                    end else if (timeout) begin
                        p_out <= '0;
                        err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mult_arbiter;
    localparam int N   = 8;
    localparam int TMO = 40;

    logic clk, rst;
    logic req0, req1;
    logic [N-1:0] a0, b0, a1, b1;
    logic ack0, ack1, done0, done1, err, mul_go, busy;
    logic [2*N-1:0] p_out;
    logic [N-1:0] mul_a, mul_b;
    logic mul_done;
    logic [2*N-1:0] mul_p;
    logic [1:0] state;

    mult_arbiter #(.N(N), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .p_out(p_out), .err(err), .mul_go(mul_go), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p), .busy(busy), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntot = 0, npass = 0, nfail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else begin
            nfail++;
            if (nfail <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Multiplier stand-in: answers k WAIT cycles after mul_go, or never.
    logic           manual = 1'b0, man_done = 1'b0;
    logic [2*N-1:0] man_p = '0;
    logic           rsp_done = 1'b0;
    logic [2*N-1:0] rsp_p = '0;
    bit             never = 0, rand_mode = 0;
    int             fixed_k = 1, left = 0;

    assign mul_done = manual ? man_done : rsp_done;
    assign mul_p    = manual ? man_p : rsp_p;

    always @(negedge clk) begin
        rsp_done = 1'b0;
        if (rst) left = 0;
        else if (mul_go) begin
            if (never || (rand_mode && $urandom_range(0, 15) == 0)) left = -1;
            else left = rand_mode ? int'($urandom_range(1, 6)) : fixed_k;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                rsp_done = 1'b1;
                rsp_p = {8'h00, mul_a} * {8'h00, mul_b};
            end
        end else if (rand_mode && $urandom_range(0, 7) == 0) begin
            rsp_done = 1'b1;
            rsp_p = 16'($urandom);
        end
    end

    // Reference model: mj = cycles since the grant edge (0 = idle);
    // done lands one cycle after completion is seen, or at TMO+2 on timeout.
    int   mj = 0, mdone_at = -1;
    bit   mg = 0, mlast = 1, merr = 0;
    logic [2*N-1:0] mp = '0;
    logic [N-1:0]   ma = '0, mb = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mj = 0; mdone_at = -1; mg = 0; mlast = 1; merr = 0; mp = '0; ma = '0; mb = '0;
        end else if (mj == 0) begin
            if (req0 || req1) begin
                mg = (req0 && req1) ? !mlast : req1;
                mlast = mg;
                ma = mg ? a1 : a0;
                mb = mg ? b1 : b0;
                mj = 1;
                mdone_at = -1;
            end
        end else begin
            if (mj >= 2 && mdone_at < 0) begin
                if (mul_done) begin
                    mdone_at = mj + 1; mp = mul_p; merr = 0;
                end else if (mj == TMO + 1) begin
                    mdone_at = mj + 1; mp = '0; merr = 1;
                end
            end
            if (mj == mdone_at) mj = 0;
            else mj++;
        end
    end

    // Per-cycle compare plus an event log for the directed checks.
    int cyc = 0, done_cnt = 0, last_ack_cyc = 0, last_done_cyc = 0;
    int n_ack [2] = '{0, 0};
    int n_done[2] = '{0, 0};
    bit last_ack_who = 0, last_done_who = 0, last_err = 0, ack_go = 0;
    logic [2*N-1:0] last_p = '0, p_done1 = '0;
    logic [N-1:0] ack_a = '0, ack_b = '0;
    bit gq[$];

    always @(posedge clk) begin
        logic [1:0] es;
        #1;
        if (!rst) begin
            cyc++;
            es = (mj == 0) ? 2'b00 : (mj == 1) ? 2'b01 : (mj == mdone_at) ? 2'b11 : 2'b10;
            chk("state", state, es);
            chk("busy", busy, mj != 0);
            chk("ack0", ack0, mj == 1 && !mg);
            chk("ack1", ack1, mj == 1 && mg);
            chk("mul_go", mul_go, mj == 1);
            chk("done0", done0, mj != 0 && mj == mdone_at && !mg);
            chk("done1", done1, mj != 0 && mj == mdone_at && mg);
            chk("mul_a", mul_a, ma);
            chk("mul_b", mul_b, mb);
            chk("p_out", p_out, mp);
            chk("err", err, merr);
            if (ack0 || ack1) begin
                n_ack[ack1]++;
                gq.push_back(ack1);
                last_ack_cyc = cyc; last_ack_who = ack1;
                ack_a = mul_a; ack_b = mul_b; ack_go = mul_go;
            end
            if (done0 || done1) begin
                n_done[done1]++;
                done_cnt++;
                last_done_cyc = cyc; last_done_who = done1;
                last_p = p_out; last_err = err;
                if (done1) p_done1 = p_out;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", n < 300, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, dc, bad, waits, alt_bad;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
        a0 = 8'd5; b0 = 8'd7; a1 = '0; b1 = '0;
        fixed_k = 4;

        // Reset state, then the first transaction straight out of reset.
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", p_out, 0);
        chk("rst_mul_a", mul_a, 0);
        rst = 1'b0;
        t0 = cyc;
        @(negedge clk);
        req0 = 1'b0;
        repeat (7) @(negedge clk);
        chk("t1_ack_cycle", last_ack_cyc - t0, 1);
        chk("t1_ack_who", last_ack_who, 0);
        chk("t1_go_at_ack", ack_go, 1);
        chk("t1_mul_a", ack_a, 5);
        chk("t1_mul_b", ack_b, 7);
        chk("t1_done_cycle", last_done_cyc - t0, 6);
        chk("t1_p", last_p, 35);
        chk("t1_err", last_err, 0);
        chk("t1_no_ch1", n_ack[1] + n_done[1], 0);

        // Both clients hammering: grants must alternate.
        wait_idle();
        gq.delete();
        a1 = 8'd3; b1 = 8'd9; fixed_k = 2;
        req0 = 1'b1; req1 = 1'b1;
        repeat (40) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();
        alt_bad = 0;
        for (int i = 1; i < gq.size(); i++) if (gq[i] == gq[i-1]) alt_bad++;
        chk("t2_grants", gq.size() >= 4, 1);
        chk("t2_first_tie", gq[0], 1);
        chk("t2_alternate", alt_bad, 0);
        chk("t2_p_done1", p_done1, 27);

        // Watchdog timeout, then a normal transaction.
        never = 1;
        req0 = 1'b1; a0 = 8'd11; b0 = 8'd13;
        t0 = cyc;
        @(negedge clk);
        req0 = 1'b0;
        repeat (45) @(negedge clk);
        chk("t3_done_cycle", last_done_cyc - t0, 42);
        chk("t3_who", last_done_who, 0);
        chk("t3_err", last_err, 1);
        chk("t3_p", last_p, 0);
        wait_idle();
        never = 0; fixed_k = 3;
        req0 = 1'b1; a0 = 8'd6; b0 = 8'd7;
        @(negedge clk);
        req0 = 1'b0;
        repeat (8) @(negedge clk);
        chk("t3b_err", last_err, 0);
        chk("t3b_p", last_p, 42);

        // Stray completions in IDLE and ISSUE are ignored.
        wait_idle();
        dc = done_cnt;
        manual = 1'b1;
        req0 = 1'b1; a0 = 8'd2; b0 = 8'd2; man_done = 1'b1; man_p = 16'h1234;
        @(negedge clk);
        req0 = 1'b0; man_done = 1'b1; man_p = 16'h5678;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        man_done = 1'b1; man_p = 16'hFF01;
        @(negedge clk);
        man_done = 1'b0;
        repeat (6) @(negedge clk);
        manual = 1'b0;
        chk("t4_done_count", done_cnt - dc, 1);
        chk("t4_p", last_p, 16'hFF01);
        chk("t4_err", last_err, 0);

        // Asynchronous reset in the middle of WAIT.
        wait_idle();
        never = 1;
        req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
        @(negedge clk);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_in_wait", state, 2'b10);
        dc = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("t5_state", state, 0);
        chk("t5_busy", busy, 0);
        chk("t5_p", p_out, 0);
        chk("t5_done", done0 | done1, 0);
        @(negedge clk);
        @(negedge clk);
        never = 0; fixed_k = 1;
        req0 = 1'b1; req1 = 1'b1; a0 = 8'd2; b0 = 8'd3; a1 = 8'd4; b1 = 8'd5;
        rst = 1'b0;
        t0 = cyc;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        chk("t5_no_done", done_cnt - dc, 0);
        chk("t5_tie_winner", last_ack_who, 0);
        chk("t5_ack_cycle", last_ack_cyc - t0, 1);
        repeat (4) @(negedge clk);
        chk("t5_p_after", last_p, 6);

        // Operand boundary, with operands watched through WAIT.
        wait_idle();
        fixed_k = 5;
        req0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
        @(negedge clk);
        req0 = 1'b0;
        bad = 0; waits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state == 2'b10) begin
                waits++;
                if (mul_a != 8'hFF || mul_b != 8'hFF) bad++;
            end
        end
        chk("t6_wait_cycles", waits, 5);
        chk("t6_operand_stable", bad, 0);
        chk("t6_p", p_out, 16'hFE01);

        // Randomized traffic with random latencies, timeouts and stray pulses.
        wait_idle();
        rand_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (req0) begin
                if (ack0 && $urandom_range(0, 1) == 1) req0 = 1'b0;
                else if (ack0) begin a0 = 8'($urandom); b0 = 8'($urandom); end
            end else if ($urandom_range(0, 2) == 0) begin
                req0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom);
            end
            if (req1) begin
                if (ack1 && $urandom_range(0, 1) == 1) req1 = 1'b0;
                else if (ack1) begin a1 = 8'($urandom); b1 = 8'($urandom); end
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        rand_mode = 0;
        wait_idle();
        chk("rand_progress", done_cnt > 50, 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
